// File: rtl/spect_accum.sv
// Multi-frame power-spectrum accumulator: sums |X[k]|^2 over acc_num transform frames
// into an NBIN x 40 buffer, then drains the totals in bin order with valid/ready.
module spect_accum #(
  parameter int NBIN = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         acc_num,
  input  logic               dv,
  input  logic [9:0]         xk_index,
  input  logic signed [15:0] xk_re,
  input  logic signed [15:0] xk_im,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [39:0]        out_data,
  output logic [9:0]         out_index,
  output logic               out_last,
  output logic               busy,
  output logic               acc_done
);

  localparam int AW = (NBIN > 1) ? $clog2(NBIN) : 1;
  localparam logic [9:0]    LAST_BIN = 10'(NBIN - 1);
  localparam logic [AW-1:0] ONE_A    = 1;

  typedef enum logic [1:0] {IDLE, SYNC, ACCUM, DRAIN} state_t;
  state_t state, state_nxt;

  logic [7:0]  acc_lim, frame_cnt;
  logic        retiring;
  logic        take, frame_end, last_frame, go_drain, xfer;
  logic        vld_p0, vld_p1, vld_p2;
  logic        first_p0, first_p1, first_p2;
  logic [AW-1:0] idx_p0, idx_p1, idx_p2;
  logic signed [15:0] re_p0, im_p0;
  logic [31:0] sq_re_p1, sq_im_p1, pwr_p2;
  logic [39:0] mem [NBIN];
  logic [39:0] rdata, wdata;
  logic [AW-1:0] raddr;

  // Square of a signed 16-bit value; the result is never negative and fits 31 bits.
  function automatic logic [31:0] sq16(input logic signed [15:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    return $unsigned(w * w);
  endfunction

  assign xfer       = out_valid && out_ready;
  assign last_frame = (frame_cnt + 8'd1) == acc_lim;
  assign busy       = (state != IDLE);
  assign out_data   = out_valid ? rdata : '0;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    frame_end = 1'b0;
    go_drain  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SYNC;
      SYNC:  if (dv && xk_index == 10'd0) begin
               take      = 1'b1;
               state_nxt = ACCUM;
             end
      ACCUM: if (retiring) begin
               if (!(vld_p0 || vld_p1 || vld_p2)) begin
                 go_drain  = 1'b1;
                 state_nxt = DRAIN;
               end
             end else if (dv) begin
               take      = (xk_index <= LAST_BIN);
               frame_end = (xk_index == 10'd1023);
             end
      DRAIN: if (xfer && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_lim   <= 8'd1;
      frame_cnt <= 8'd0;
      retiring  <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_index <= 10'd0;
      out_last  <= 1'b0;
      acc_done  <= 1'b0;
    end else begin
      vld_p0   <= take;
      vld_p1   <= vld_p0;
      vld_p2   <= vld_p1;
      acc_done <= 1'b0;
      if (state == IDLE && start) begin
        acc_lim   <= (acc_num == 8'd0) ? 8'd1 : acc_num;
        frame_cnt <= 8'd0;
        retiring  <= 1'b0;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 8'd1;
        if (last_frame) retiring <= 1'b1;
      end
      if (go_drain) begin
        retiring  <= 1'b0;
        out_index <= 10'd0;
        out_last  <= 1'b0;
      end
      // The first DRAIN cycle only issues the read of bin 0; valid rises next cycle.
      if (state == DRAIN) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_last  <= (LAST_BIN == 10'd0);
        end else if (xfer) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= 10'd0;
            acc_done  <= 1'b1;
          end else begin
            out_index <= out_index + 10'd1;
            out_last  <= (out_index + 10'd1 == LAST_BIN);
          end
        end
      end
    end
  end

  // Stage 1: register sample
  always_ff @(posedge clk) begin
    if (take) begin
      re_p0    <= xk_re;
      im_p0    <= xk_im;
      idx_p0   <= xk_index[AW-1:0];
      first_p0 <= (frame_cnt == 8'd0);
    end
  end

  // Stage 2: squares
  always_ff @(posedge clk) begin
    sq_re_p1 <= sq16(re_p0);
    sq_im_p1 <= sq16(im_p0);
    idx_p1   <= idx_p0;
    first_p1 <= first_p0;
  end

  // Stage 3: power sum, buffer read lands alongside it
  always_ff @(posedge clk) begin
    pwr_p2   <= sq_re_p1 + sq_im_p1;
    idx_p2   <= idx_p1;
    first_p2 <= first_p1;
  end

  // During DRAIN the address re-reads the held bin on a stall so rdata stays put.
  always_comb begin
    raddr = idx_p1;
    if (state == DRAIN) raddr = xfer ? (out_index[AW-1:0] + ONE_A) : out_index[AW-1:0];
  end

  assign wdata = first_p2 ? 40'(pwr_p2) : (rdata + 40'(pwr_p2));

  // Stage 4: buffer write
  always_ff @(posedge clk) begin
    if (vld_p2) mem[idx_p2] <= wdata;
    rdata <= mem[raddr];
  end

endmodule
